seg7_capture_decoder: RTL and testbench

- Inverse of the team's hex 7-seg driver: samples an active-low 7-segment bus, filters glitches, and decodes each stable new pattern back to a 4-bit value.
- Flags blank and illegal patterns.
- Presents each result on a valid/ready output port.
- Used for loopback checking of display paths and for reading external 7-seg-driven boards back into the FPGA.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 38 +++
 rtl/seg7_capture_decoder.sv | 126 ++++++++++++
 tb/tb_seg7_capture_decoder.sv | 117 +++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph constants (active-low, bit 6 = g .. bit 0 = a)
// and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic { WAIT, SETTLE } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph decoder: 7-seg pattern -> hex value plus
// blank/invalid flags. Data is 0 whenever the pattern is not a digit.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] data_o,
  output logic       blank_o,
  output logic       invalid_o
);

  always_comb begin
    data_o    = 4'h0;
    blank_o   = 1'b0;
    invalid_o = 1'b0;
    case (seg_i)
      SEG_0:     data_o = 4'h0;
      SEG_1:     data_o = 4'h1;
      SEG_2:     data_o = 4'h2;
      SEG_3:     data_o = 4'h3;
      SEG_4:     data_o = 4'h4;
      SEG_5:     data_o = 4'h5;
      SEG_6:     data_o = 4'h6;
      SEG_7:     data_o = 4'h7;
      SEG_8:     data_o = 4'h8;
      SEG_9:     data_o = 4'h9;
      SEG_A:     data_o = 4'hA;
      SEG_B:     data_o = 4'hB;
      SEG_C:     data_o = 4'hC;
      SEG_D:     data_o = 4'hD;
      SEG_E:     data_o = 4'hE;
      SEG_F:     data_o = 4'hF;
      SEG_BLANK: blank_o = 1'b1;
      default:   invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Samples an asynchronous active-low 7-seg bus, debounces each new pattern
// for STABLE_CYCLES cycles, and presents the decode on a valid/ready port.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int DATA_WIDTH    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_i,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  blank_o,
  output logic                  invalid_o,
  output logic                  out_valid_o,
  output logic                  overflow_o
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [6:0]            sync1_q, seg_s_q, last_q, last_d, cand_q, cand_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  blank_q, blank_d, invalid_q, invalid_d;
  logic                  valid_q, valid_d, ovf_q, ovf_d;
  logic                  accept;
  logic [3:0]            dec_data;
  logic                  dec_blank, dec_invalid;

  seg7_decode u_decode (
    .seg_i     (cand_q),
    .data_o    (dec_data),
    .blank_o   (dec_blank),
    .invalid_o (dec_invalid)
  );

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    accept  = 1'b0;
    case (state_q)
      WAIT: begin
        if (seg_s_q != last_q) begin
          state_d = SETTLE;
          cand_d  = seg_s_q;
          cnt_d   = CNT_W'(1);
        end
      end
      SETTLE: begin
        if (seg_s_q != cand_q) begin
          // Bouncing back to the already-reported pattern is not news.
          if (seg_s_q == last_q) begin
            state_d = WAIT;
          end else begin
            cand_d = seg_s_q;
            cnt_d  = CNT_W'(1);
          end
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          accept  = 1'b1;
          last_d  = cand_q;
          state_d = WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_comb begin
    data_d    = data_q;
    blank_d   = blank_q;
    invalid_d = invalid_q;
    valid_d   = valid_q;
    ovf_d     = 1'b0;
    if (accept) begin
      data_d    = DATA_WIDTH'(dec_data);
      blank_d   = dec_blank;
      invalid_d = dec_invalid;
      valid_d   = 1'b1;
      ovf_d     = valid_q && !out_ready_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= SEG_BLANK;
      seg_s_q   <= SEG_BLANK;
      last_q    <= SEG_BLANK;
      cand_q    <= SEG_BLANK;
      cnt_q     <= '0;
      state_q   <= WAIT;
      data_q    <= '0;
      blank_q   <= 1'b0;
      invalid_q <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync1_q   <= seg_i;
      seg_s_q   <= sync1_q;
      last_q    <= last_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      data_q    <= data_d;
      blank_q   <= blank_d;
      invalid_q <= invalid_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign data_o      = data_q;
  assign blank_o     = blank_q;
  assign invalid_o   = invalid_q;
  assign out_valid_o = valid_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder. Observed word is
// {out_valid, data[3:0], blank, invalid, overflow}.
module tb_seg7_capture_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic       out_ready;
  logic [3:0] data;
  logic       blank, invalid, out_valid, overflow;

  int checks = 0;
  int errors = 0;

  seg7_capture_decoder #(.DATA_WIDTH(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_i       (seg),
    .out_ready_i (out_ready),
    .data_o      (data),
    .blank_o     (blank),
    .invalid_o   (invalid),
    .out_valid_o (out_valid),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {out_valid, data, blank, invalid, overflow};
  endfunction

  // {valid, data, blank, invalid, overflow}
  function automatic logic [7:0] ex(logic v, logic [3:0] d, logic b, logic i, logic o);
    return {v, d, b, i, o};
  endfunction

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic chk_valid_low(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, {7'd0, out_valid}, 8'd0);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; seg = 7'b1111111; out_ready = 1'b0;
    cyc(3);
    chk("reset_state", obs(), ex(0, 4'h0, 0, 0, 0));
    rst_n = 1'b1;

    // Idle blank bus: nothing reported.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_blank", {6'd0, out_valid, overflow}, 8'd0);
    end

    // Digit 2, 7-edge latency, single-cycle valid with ready high.
    out_ready = 1'b1; seg = 7'b0100100;
    cyc(6); chk("d2_before", obs(), ex(0, 4'h0, 0, 0, 0));
    cyc(1); chk("d2_accept", obs(), ex(1, 4'h2, 0, 0, 0));
    cyc(1); chk("d2_xfer",   obs(), ex(0, 4'h2, 0, 0, 0));
    chk_valid_low("d2_no_repeat", 4);

    // Short glitch to 5 then back to 2: no result.
    seg = 7'b0010010; cyc(2); seg = 7'b0100100;
    chk_valid_low("glitch", 10);
    seg = 7'b0010010;
    cyc(6); chk("d5_before", obs(), ex(0, 4'h2, 0, 0, 0));
    cyc(1); chk("d5_accept", obs(), ex(1, 4'h5, 0, 0, 0));
    chk_valid_low("d5_once", 3);

    // Backpressure: second accept overwrites and pulses overflow.
    out_ready = 1'b0; seg = 7'b0001000;
    cyc(7); chk("dA_accept", obs(), ex(1, 4'hA, 0, 0, 0));
    seg = 7'b0000011;
    cyc(6); chk("dA_held",   obs(), ex(1, 4'hA, 0, 0, 0));
    cyc(1); chk("dB_ovf",    obs(), ex(1, 4'hB, 0, 0, 1));
    cyc(1); chk("dB_ovf_end", obs(), ex(1, 4'hB, 0, 0, 0));
    out_ready = 1'b1;
    cyc(1); chk("dB_xfer",   obs(), ex(0, 4'hB, 0, 0, 0));

    // Invalid glyph, then blank as a legitimate result.
    seg = 7'b0110110;
    cyc(6); chk("inv_before", {7'd0, out_valid}, 8'd0);
    cyc(1); chk("inv_accept", obs(), ex(1, 4'h0, 0, 1, 0));
    seg = 7'b1111111;
    cyc(7); chk("blank_accept", obs(), ex(1, 4'h0, 1, 0, 0));
    cyc(1); chk("blank_xfer", obs(), ex(0, 4'h0, 1, 0, 0));

    // Reset two cycles into SETTLE on 7; candidate must be discarded.
    seg = 7'b1111000;
    cyc(4);
    rst_n = 1'b0;
    #1 chk("rst_async", obs(), ex(0, 4'h0, 0, 0, 0));
    cyc(2); chk("rst_hold", obs(), ex(0, 4'h0, 0, 0, 0));
    rst_n = 1'b1;
    cyc(6); chk("d7_before", obs(), ex(0, 4'h0, 0, 0, 0));
    cyc(1); chk("d7_accept", obs(), ex(1, 4'h7, 0, 0, 0));
    cyc(1); chk("d7_xfer",   obs(), ex(0, 4'h7, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
